// File: rtl/insn_mem_loader_pkg.sv
// Shared types for the RV32I instruction-memory loader.
// State encodings are fixed so that existing waveforms and legacy decoders stay valid.
package rv_loader_pkg;

  localparam int unsigned LOADER_COUNT_W = 16;

  localparam logic [2:0] ST_LEN_LO = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_CHK    = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  typedef enum logic [2:0] {
    LEN_LO = ST_LEN_LO,
    LEN_HI = ST_LEN_HI,
    DATA   = ST_DATA,
    WRITE  = ST_WRITE,
    CHK    = ST_CHK,
    DONE   = ST_DONE,
    ERROR  = ST_ERROR
  } loader_state_t;

endpackage

// File: rtl/insn_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The slave modport is the loader; the master modport is the stream source / memory side.
interface insn_mem_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/insn_mem_loader_word_asm.sv
// Little-endian word assembler: byte k of each group of four lands in word[8k+7:8k].
module loader_word_asm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic        o_word_full,
  output logic [31:0] o_word
);
  logic [1:0]  r_cnt;
  logic [31:0] r_word;

  // Flags the cycle the 4th byte is accepted, so the FSM can move to WRITE on that edge.
  assign o_word_full = i_en && (r_cnt == 2'd3);
  assign o_word      = r_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_word[{r_cnt, 3'b000} +: 8] <= i_byte;
      r_cnt                        <= r_cnt + 2'd1;
    end
  end
endmodule

// File: rtl/insn_mem_loader.sv
// Framed byte-stream program loader; holds the core in reset until the image is written.
// Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
module insn_mem_loader
  import rv_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  insn_mem_loader_if.slave  bus,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [31:0] LP_MAX = 32'(MAX_WORDS);

  loader_state_t               r_state, w_next;
  logic [LOADER_COUNT_W-1:0]   r_count;
  logic [ADDR_W-1:0]           r_idx;
  logic                        w_in_ready, w_accept, w_restart, w_last, w_word_full;
  logic [LOADER_COUNT_W-1:0]   w_len;
  logic [31:0]                 w_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]                  r_xor;
`endif

  assign w_in_ready = (r_state == LEN_LO) || (r_state == LEN_HI) ||
                      (r_state == DATA)   || (r_state == CHK);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_restart  = start && ((r_state == DONE) || (r_state == ERROR));
  assign w_len      = {bus.in_data, r_count[7:0]};
  // Index is not advanced past the last word, so the last word is detected as idx+1 == count.
  assign w_last     = (LOADER_COUNT_W'(r_idx) + LOADER_COUNT_W'(1)) == r_count;

  assign bus.in_ready  = w_in_ready;
  assign bus.mem_we    = (r_state == WRITE);
  assign bus.mem_addr  = r_idx;
  assign bus.mem_wdata = w_word;
  assign core_reset    = (r_state == DONE);
  assign done          = (r_state == DONE);
  assign err           = (r_state == ERROR);
  assign busy          = (r_state == LEN_HI) || (r_state == DATA) ||
                         (r_state == WRITE)  || (r_state == CHK);

  loader_word_asm u_word_asm (
    .clk         (clk),
    .rst_n       (reset),
    .i_clr       (w_restart),
    .i_en        (w_accept && (r_state == DATA)),
    .i_byte      (bus.in_data),
    .o_word_full (w_word_full),
    .o_word      (w_word)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      LEN_LO: if (w_accept) w_next = LEN_HI;
      LEN_HI: begin
        if (w_accept) begin
          if ({16'd0, w_len} > LP_MAX) w_next = ERROR;
          else if (w_len == '0)        w_next = DONE;
          else                         w_next = DATA;
        end
      end
      DATA:   if (w_word_full) w_next = WRITE;
      WRITE: begin
        if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
          w_next = CHK;
`else
          w_next = DONE;
`endif
        end else begin
          w_next = DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK:    if (w_accept) w_next = (bus.in_data == r_xor) ? DONE : ERROR;
`endif
      DONE, ERROR: if (start) w_next = LEN_LO;
      default: w_next = ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= LEN_LO;
      r_count <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (w_restart) begin
        r_count <= '0;
        r_idx   <= '0;
      end
      if (w_accept && (r_state == LEN_LO)) r_count[7:0]  <= bus.in_data;
      if (w_accept && (r_state == LEN_HI)) r_count[15:8] <= bus.in_data;
      if ((r_state == WRITE) && !w_last)   r_idx <= r_idx + 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           r_xor <= '0;
    else if (w_restart)                   r_xor <= '0;
    else if (w_accept && r_state != CHK)  r_xor <= r_xor ^ bus.in_data;
  end
`endif
endmodule

// File: tb/tb_insn_mem_loader.sv
// Directed self-checking bench for insn_mem_loader (default and LOADER_CHECKSUM_EN builds).
module tb_insn_mem_loader;
  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic core_reset, busy, done, err;
  int   total = 0;
  int   bad   = 0;
  int   viol  = 0;
  logic [9:0]  wq_addr [$];
  logic [31:0] wq_data [$];

  logic [7:0]  s3 [14] = '{8'h03, 8'h00, 8'h93, 8'h80, 8'hC0, 8'h00, 8'h13, 8'h81,
                           8'h20, 8'h01, 8'hB3, 8'hE1, 8'h20, 8'h00};
  logic [9:0]  e3_addr [3] = '{10'd0, 10'd1, 10'd2};
  logic [31:0] e3_data [3] = '{32'h00C08093, 32'h01208113, 32'h0020E1B3};
  logic [7:0]  s1 [6] = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};

  insn_mem_loader_if #(.ADDR_W(10)) bus ();

  insn_mem_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start),
    .bus        (bus),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wq_addr.push_back(bus.mem_addr);
      wq_data.push_back(bus.mem_wdata);
    end
    if (bus.mem_we === 1'b1 && bus.in_ready !== 1'b0) viol++;
    if (rst_n && bus.in_ready === 1'b0 && bus.mem_we !== 1'b1 && done !== 1'b1 && err !== 1'b1) viol++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned n = 0;
    repeat (gap) @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL send_accept: byte %h in_ready=%b required 1 within 50 cycles", b, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_writes3(input string tag);
    total++;
    if (wq_addr.size() != 3) begin
      bad++;
      $display("FAIL %s_count: writes=%0d required 3", tag, wq_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (wq_addr[i] !== e3_addr[i] || wq_data[i] !== e3_data[i]) begin
          bad++;
          $display("FAIL %s_word%0d: addr=%0d data=%h required addr=%0d data=%h",
                   tag, i, wq_addr[i], wq_data[i], e3_addr[i], e3_data[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.in_ready, bus.mem_we, core_reset, busy, done, err} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_flags: rdy/we/crst/busy/done/err=%b required 100000",
               {bus.in_ready, bus.mem_we, core_reset, busy, done, err});
    end
    total++;
    if (bus.mem_addr !== 10'd0 || bus.mem_wdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_bus: addr=%0d wdata=%h required 0/0", bus.mem_addr, bus.mem_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: in_ready=%b busy=%b required 1/0", bus.in_ready, busy);
    end
  endtask

  task automatic test_three_words();
    wq_addr.delete(); wq_data.delete();
    for (int i = 0; i < 14; i++) send_byte(s3[i], 0);
    total++;
    if (bus.mem_we !== 1'b1 || core_reset !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL last_write: we=%b crst=%b busy=%b required 1/0/1", bus.mem_we, core_reset, busy);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h11, 0);
`else
    @(negedge clk);
`endif
    total++;
    if (done !== 1'b1 || core_reset !== 1'b1 || bus.in_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_state: done=%b crst=%b rdy=%b busy=%b required 1/1/0/0",
               done, core_reset, bus.in_ready, busy);
    end
    bus.in_data = 8'hAA; bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    total++;
    if (done !== 1'b1 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL done_hold: done=%b rdy=%b required 1/0", done, bus.in_ready);
    end
    check_writes3("three");
  endtask

  task automatic test_zero_len();
    pulse_start();
    total++;
    if (bus.in_ready !== 1'b1 || core_reset !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL restart: rdy=%b crst=%b done=%b required 1/0/0", bus.in_ready, core_reset, done);
    end
    wq_addr.delete(); wq_data.delete();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    total++;
    if (done !== 1'b1 || core_reset !== 1'b1) begin
      bad++;
      $display("FAIL zero_len_done: done=%b crst=%b required 1/1", done, core_reset);
    end
    @(negedge clk);
    total++;
    if (wq_addr.size() != 0) begin
      bad++;
      $display("FAIL zero_len_writes: writes=%0d required 0", wq_addr.size());
    end
  endtask

  task automatic test_too_long();
    pulse_start();
    wq_addr.delete(); wq_data.delete();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    total++;
    if (err !== 1'b1 || core_reset !== 1'b0 || bus.in_ready !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL too_long_err: err=%b crst=%b rdy=%b done=%b required 1/0/0/0",
               err, core_reset, bus.in_ready, done);
    end
    pulse_start();
    total++;
    if (bus.in_ready !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL err_restart: rdy=%b err=%b busy=%b required 1/0/0", bus.in_ready, err, busy);
    end
  endtask

  task automatic test_max_len();
    // 1024 is the largest legal count: must enter DATA, not ERROR
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    total++;
    if (err !== 1'b0 || busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL max_len: err=%b busy=%b rdy=%b required 0/1/1", err, busy, bus.in_ready);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_gaps();
    wq_addr.delete(); wq_data.delete();
    viol = 0;
    for (int i = 0; i < 14; i++) send_byte(s3[i], $urandom_range(0, 3));
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h11, $urandom_range(0, 3));
`else
    @(negedge clk);
`endif
    @(negedge clk);
    total++;
    if (done !== 1'b1 || viol != 0) begin
      bad++;
      $display("FAIL gaps_done: done=%b ready_violations=%0d required 1/0", done, viol);
    end
    check_writes3("gaps");
  endtask

  task automatic test_reset_midload();
    pulse_start();
    wq_addr.delete(); wq_data.delete();
    for (int i = 0; i < 4; i++) send_byte(s1[i], 0);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (core_reset !== 1'b0 || bus.mem_we !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort: crst=%b we=%b busy=%b required 0/0/0", core_reset, bus.mem_we, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (wq_addr.size() != 0 || core_reset !== 1'b0) begin
      bad++;
      $display("FAIL abort_writes: writes=%0d crst=%b required 0/0", wq_addr.size(), core_reset);
    end
    for (int i = 0; i < 6; i++) send_byte(s1[i], 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h09, 0);
`else
    @(negedge clk);
`endif
    @(negedge clk);
    total++;
    if (done !== 1'b1 || wq_addr.size() != 1) begin
      bad++;
      $display("FAIL fresh_done: done=%b writes=%0d required 1/1", done, wq_addr.size());
    end else begin
      total++;
      if (wq_addr[0] !== 10'd0 || wq_data[0] !== 32'h12345678) begin
        bad++;
        $display("FAIL fresh_word: addr=%0d data=%h required 0/12345678", wq_addr[0], wq_data[0]);
      end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(s1[i], 0);
    send_byte(8'h02, 0);
    total++;
    if (err !== 1'b1 || core_reset !== 1'b0) begin
      bad++;
      $display("FAIL cks_bad: err=%b crst=%b required 1/0", err, core_reset);
    end
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(s1[i], 0);
    send_byte(8'h09, 0);
    total++;
    if (done !== 1'b1 || err !== 1'b0 || core_reset !== 1'b1) begin
      bad++;
      $display("FAIL cks_good: done=%b err=%b crst=%b required 1/0/1", done, err, core_reset);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_three_words();
    test_zero_len();
    test_too_long();
    test_max_len();
    test_gaps();
    test_reset_midload();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
